// File: rtl/hdc_stream_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hdc_stream_classifier                                      |
// | Description : Streaming hyperdimensional text classifier. Characters are |
// |               bundled into per-dimension saturating accumulators, the    |
// |               sign-binarised message is compared against class           |
// |               prototypes by Hamming distance, and the nearest class is  |
// |               reported.                                                  |
// | Options     : HDC_DIST_OUT_EN adds the res_dist output (winner distance) |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hdc_stream_classifier #(
  parameter int DIM       = 10000,
  parameter int CHUNK     = 16,
  parameter int NUM_CHAR  = 37,
  parameter int NUM_CLASS = 2,
  parameter int CNT_W     = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_char,
  input  logic                         in_last,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(NUM_CLASS)-1:0] res_class,
  output logic                         res_tie,
  input  logic                         mem_we,
  input  logic                         mem_sel,
  input  logic [31:0]                  mem_addr,
  input  logic [CHUNK-1:0]             mem_wdata,
  output logic                         busy
`ifdef HDC_DIST_OUT_EN
  ,
  output logic [31:0]                  res_dist
`endif
);

  localparam int c_words      = DIM / CHUNK;
  localparam int c_item_depth = NUM_CHAR * c_words;
  localparam int c_cls_depth  = NUM_CLASS * c_words;
  localparam int c_ia_w       = (c_item_depth > 1) ? $clog2(c_item_depth) : 1;
  localparam int c_ca_w       = (c_cls_depth > 1) ? $clog2(c_cls_depth) : 1;
  localparam int c_ww         = (c_words > 1) ? $clog2(c_words) : 1;
  localparam int c_cw         = $clog2(NUM_CLASS);
  localparam int c_pw         = $clog2(CHUNK + 1);
  localparam int c_dw         = $clog2(DIM + 1);

  localparam logic [c_ww-1:0] c_word_last = c_ww'(c_words - 1);
  localparam logic [c_cw-1:0] c_cls_last  = c_cw'(NUM_CLASS - 1);

  localparam logic signed [CNT_W-1:0] c_acc_max  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] c_acc_min  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] c_acc_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [CNT_W-1:0] c_acc_neg1 = {CNT_W{1'b1}};
  localparam logic signed [CNT_W-1:0] c_acc_zero = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_CMP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Bit-packed hypervector stores: bit 1 means +1, bit 0 means -1
  logic [CHUNK-1:0] r_item_mem [c_item_depth];
  logic [CHUNK-1:0] r_cls_mem  [c_cls_depth];

  logic signed [CNT_W-1:0] r_acc [c_words][CHUNK];
  logic [c_dw-1:0]         r_dist [NUM_CLASS];

  logic [7:0]      r_sym;
  logic            r_last;
  logic            r_clr;
  logic            r_open;
  logic            r_fin;
  logic [c_ww-1:0] r_word;
  logic [c_cw-1:0] r_cls;
  logic [c_cw-1:0] r_res_class;
  logic            r_res_tie;

  logic [7:0]       w_lower;
  logic [7:0]       w_sym;
  logic             w_xfer;
  logic [c_ia_w-1:0] w_item_addr;
  logic [c_ca_w-1:0] w_cls_addr;
  logic [CHUNK-1:0] w_item_word;
  logic [CHUNK-1:0] w_cls_word;
  logic [CHUNK-1:0] w_msg;
  logic [c_pw-1:0]  w_pop;
  logic [c_cw-1:0]  w_best_idx;
  logic [c_dw-1:0]  w_best_dist;
  logic             w_tie;

  assign w_xfer      = in_valid && in_ready;
  assign busy        = (r_state != S_IDLE) || r_open;
  assign res_class   = r_res_class;
  assign res_tie     = r_res_tie;
  assign w_item_addr = c_ia_w'(r_sym) * c_ia_w'(c_words) + c_ia_w'(r_word);
  assign w_cls_addr  = c_ca_w'(r_cls) * c_ca_w'(c_words) + c_ca_w'(r_word);
  assign w_item_word = r_item_mem[w_item_addr];
  assign w_cls_word  = r_cls_mem[w_cls_addr];

  // Character to symbol: fold upper case, letters 11..36, digits 1..10, else 0
  always_comb begin
    w_lower = in_char;
    if (in_char >= 8'h41 && in_char <= 8'h5A) w_lower = in_char + 8'h20;
    w_sym = 8'd0;
    if (w_lower >= 8'h61 && w_lower <= 8'h7A)      w_sym = w_lower - 8'h61 + 8'd11;
    else if (w_lower >= 8'h30 && w_lower <= 8'h39) w_sym = w_lower - 8'h30 + 8'd1;
  end

  // Inline sign binarisation of the current accumulator word and XOR popcount
  always_comb begin
    w_msg = '0;
    w_pop = '0;
    for (int j = 0; j < CHUNK; j++) begin
      w_msg[j] = (r_acc[r_word][j] > c_acc_zero);
      w_pop    = w_pop + c_pw'(w_msg[j] ^ w_cls_word[j]);
    end
  end

  // Minimum-distance search: strict less-than keeps the lowest index on ties
  always_comb begin
    w_best_idx  = '0;
    w_best_dist = r_dist[0];
    w_tie       = 1'b0;
    for (int i = 1; i < NUM_CLASS; i++) begin
      if (r_dist[i] < w_best_dist) begin
        w_best_dist = r_dist[i];
        w_best_idx  = c_cw'(i);
      end
    end
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (c_cw'(i) != w_best_idx && r_dist[i] == w_best_dist) w_tie = 1'b1;
    end
  end

  // Memory load port, only while no message is in flight and only in range
  always_ff @(posedge clk) begin
    if (mem_we && !busy) begin
      if (!mem_sel && mem_addr < 32'(c_item_depth))
        r_item_mem[mem_addr[c_ia_w-1:0]] <= mem_wdata;
      else if (mem_sel && mem_addr < 32'(c_cls_depth))
        r_cls_mem[mem_addr[c_ca_w-1:0]] <= mem_wdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = reset;
        if (in_valid && reset) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (r_word == c_word_last) w_state_nxt = r_last ? S_CMP : S_IDLE;
      end
      S_CMP: begin
        if (r_fin) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: bundling, distance accumulation and result capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_open      <= 1'b0;
      r_fin       <= 1'b0;
      r_word      <= '0;
      r_cls       <= '0;
      r_res_class <= '0;
      r_res_tie   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_sym  <= w_sym;
            r_last <= in_last;
            r_clr  <= !r_open;
            r_open <= 1'b1;
            r_word <= '0;
          end
        end
        S_ACCUM: begin
          // First character of a message overwrites instead of adding
          for (int j = 0; j < CHUNK; j++) begin
            if (r_clr)
              r_acc[r_word][j] <= w_item_word[j] ? c_acc_one : c_acc_neg1;
            else if (w_item_word[j] && r_acc[r_word][j] != c_acc_max)
              r_acc[r_word][j] <= r_acc[r_word][j] + c_acc_one;
            else if (!w_item_word[j] && r_acc[r_word][j] != c_acc_min)
              r_acc[r_word][j] <= r_acc[r_word][j] - c_acc_one;
          end
          if (r_word == c_word_last) begin
            r_word <= '0;
            r_cls  <= '0;
            r_fin  <= 1'b0;
            for (int i = 0; i < NUM_CLASS; i++) r_dist[i] <= '0;
          end else begin
            r_word <= r_word + 1'b1;
          end
        end
        S_CMP: begin
          // One class word per cycle, then a final cycle to latch the winner
          if (!r_fin) begin
            r_dist[r_cls] <= r_dist[r_cls] + c_dw'(w_pop);
            if (r_word == c_word_last) begin
              r_word <= '0;
              if (r_cls == c_cls_last) r_fin <= 1'b1;
              else                     r_cls <= r_cls + 1'b1;
            end else begin
              r_word <= r_word + 1'b1;
            end
          end else begin
            r_res_class <= w_best_idx;
            r_res_tie   <= w_tie;
          end
        end
        S_DONE: begin
          if (res_ready) r_open <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef HDC_DIST_OUT_EN
  logic [31:0] r_res_dist;
  assign res_dist = r_res_dist;

  // Winner distance, captured alongside the class
  always_ff @(posedge clk) begin
    if (!reset)                      r_res_dist <= '0;
    else if (r_state == S_CMP && r_fin) r_res_dist <= 32'(w_best_dist);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdc_stream_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hdc_stream_classifier                                   |
// | Description : Directed self-checking bench for hdc_stream_classifier     |
// |               (DIM=64, CHUNK=16, NUM_CLASS=2, CNT_W=9).                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hdc_stream_classifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        in_last;
  logic        res_valid;
  logic        res_ready;
  logic [0:0]  res_class;
  logic        res_tie;
  logic        mem_we;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
`ifdef HDC_DIST_OUT_EN
  logic [31:0] res_dist;
`endif

  int checks   = 0;
  int failures = 0;

  hdc_stream_classifier #(
    .DIM(64), .CHUNK(16), .NUM_CHAR(37), .NUM_CLASS(2), .CNT_W(9)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class), .res_tie(res_tie),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy)
`ifdef HDC_DIST_OUT_EN
    , .res_dist(res_dist)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic mem_write(input logic sel, input int addr, input logic [15:0] data);
    mem_we = 1'b1; mem_sel = sel; mem_addr = addr; mem_wdata = data;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input logic last);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_char = c; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic cls, input logic tie);
    int n = 0;
    while (res_valid !== 1'b1 && n < 200) begin tick(); n++; end
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_class"}, {31'd0, res_class}, {31'd0, cls});
    check({tag, "_tie"},   {31'd0, res_tie},   {31'd0, tie});
`ifdef HDC_DIST_OUT_EN
    check({tag, "_dist"}, res_dist, 32'd0);
`endif
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_released"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    logic seen;
    reset = 1'b0; in_valid = 1'b0; in_char = 8'h00; in_last = 1'b0;
    res_ready = 1'b0; mem_we = 1'b0; mem_sel = 1'b0; mem_addr = 32'd0; mem_wdata = 16'h0;

    // Reset state
    tick(); tick();
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("rst_res_valid",    {31'd0, res_valid}, 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_busy",     {31'd0, busy},     32'd0);
    check("post_rst_class",    {31'd0, res_class}, 32'd0);
    check("post_rst_tie",      {31'd0, res_tie},   32'd0);
`ifdef HDC_DIST_OUT_EN
    check("post_rst_dist", res_dist, 32'd0);
`endif

    // Memory image: sym11 ('a') all ones, sym12 ('b') all zeros,
    // class0 all ones, class1 all zeros
    for (int w = 0; w < 4; w++) begin
      mem_write(1'b0, 11*4 + w, 16'hFFFF);
      mem_write(1'b0, 12*4 + w, 16'h0000);
      mem_write(1'b1, w,        16'hFFFF);
      mem_write(1'b1, 4 + w,    16'h0000);
    end
    // Out-of-range class address must not alias onto word 0
    mem_write(1'b1, 8, 16'h0000);
    check("oor_write_ignored", {16'd0, dut.r_cls_mem[0]}, 32'h0000FFFF);

    // "a": latency 13 cycles from transfer, class0, no tie
    send_char("a", 1'b1);
    check("a_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 12; i++) tick();
    check("a_lat12_low", {31'd0, res_valid}, 32'd0);
    tick();
    check("a_lat13_high", {31'd0, res_valid}, 32'd1);
    get_result("a", 1'b0, 1'b0);
    check("a_idle_busy", {31'd0, busy}, 32'd0);

    // "Bb": upper case folds to 'b', all -1 -> class1
    send_char("B", 1'b0);
    send_char("b", 1'b1);
    get_result("Bb", 1'b1, 1'b0);

    // "ab": sums to zero, all bits 0 -> class1
    send_char("a", 1'b0);
    send_char("b", 1'b1);
    get_result("ab", 1'b1, 1'b0);

    // "A" alone behaves as "a"
    send_char("A", 1'b1);
    get_result("A", 1'b0, 1'b0);

    // Back-pressure in DONE: outputs held, no new input accepted
    send_char("b", 1'b1);
    begin
      int n = 0;
      while (res_valid !== 1'b1 && n < 200) begin tick(); n++; end
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    {31'd0, res_valid}, 32'd1);
      check("bp_class",    {31'd0, res_class}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready},  32'd0);
      tick();
    end
    get_result("bp", 1'b1, 1'b0);

    // Equal prototypes: tie, lowest index wins
    for (int w = 0; w < 4; w++) mem_write(1'b1, 4 + w, 16'hFFFF);
    send_char("a", 1'b1);
    get_result("tie", 1'b0, 1'b1);
    for (int w = 0; w < 4; w++) mem_write(1'b1, 4 + w, 16'h0000);

    // 300 x 'a': accumulators saturate at +255
    for (int i = 0; i < 299; i++) send_char("a", 1'b0);
    send_char("a", 1'b1);
    get_result("sat", 1'b0, 1'b0);
    check("sat_acc_first", 32'(dut.r_acc[0][0]),  32'd255);
    check("sat_acc_last",  32'(dut.r_acc[3][15]), 32'd255);

    // Reset during CMP abandons the message
    send_char("a", 1'b1);
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b0;
    tick();
    check("midrst_valid",    {31'd0, res_valid}, 32'd0);
    check("midrst_busy",     {31'd0, busy},      32'd0);
    check("midrst_in_ready", {31'd0, in_ready},  32'd0);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); seen = seen | res_valid; end
    check("midrst_no_result", {31'd0, seen}, 32'd0);

    // "b" with an ignored memory write during ACCUM
    send_char("b", 1'b1);
    check("we_busy", {31'd0, busy}, 32'd1);
    mem_write(1'b1, 4, 16'hFFFF);
    get_result("after_rst", 1'b1, 1'b0);
    check("we_ignored", {16'd0, dut.r_cls_mem[4]}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); seen = seen | res_valid; end
    check("single_result", {31'd0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
